// File: rtl/mdu.sv
// ---------------------------------------------------------------------------
// mdu -- multiply/divide unit for the E stage of the 5-stage MIPS pipeline.
//
// Holds the architectural HI/LO pair and models the multi-cycle latency of
// mult/multu/div/divu. The result is computed combinationally from the
// operands present on the start cycle and parked in a pending register. It
// is committed to HI/LO when the busy window expires. mthi/mtlo write HI/LO
// directly on the start edge and never raise busy.
//
// Ports
//   clk    in   1   clock, all state updates on posedge
//   rst    in   1   synchronous active-high reset (aborts in-flight work)
//   start  in   1   E-stage instruction is an MDU op, qualifies op
//   op     in   3   0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo,
//                   7 reserved (treated as none)
//   a      in   32  rs operand (forwarded)
//   b      in   32  rt operand (forwarded)
//   busy   out  1   computation in flight (registered)
//   hi     out  32  architectural HI (registered)
//   lo     out  32  architectural LO (registered)
// ---------------------------------------------------------------------------
module mdu #(
   parameter int MULT_CYCLES = 5,
   parameter int DIV_CYCLES  = 10
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic [2:0]  op,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   localparam int CW = $clog2(DIV_CYCLES + 1);

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   state_t        r_state;
   logic [CW-1:0] r_cnt;
   logic          r_busy;
   logic [31:0]   r_hi;
   logic [31:0]   r_lo;
   logic [31:0]   r_pend_hi;
   logic [31:0]   r_pend_lo;
   logic          r_commit;     // cleared for divide-by-zero: HI/LO untouched

   // ---------------- multiply ----------------
   logic signed [63:0] w_a_sx;
   logic signed [63:0] w_b_sx;
   logic        [63:0] w_prod_s;
   logic        [63:0] w_prod_u;

   assign w_a_sx   = $signed({{32{a[31]}}, a});
   assign w_b_sx   = $signed({{32{b[31]}}, b});
   assign w_prod_s = w_a_sx * w_b_sx;
   assign w_prod_u = {32'd0, a} * {32'd0, b};

   // ---------------- divide ----------------
   // Signed divide is done on magnitudes and the signs re-applied, which keeps
   // 0x80000000 / -1 well defined (magnitude 0x80000000, positive sign wraps
   // back to 0x80000000). A zero divisor is replaced by 1 purely to keep the
   // datapath free of X; that result is never committed.
   logic        w_b_zero;
   logic [31:0] w_b_safe;
   logic [31:0] w_abs_a;
   logic [31:0] w_abs_b;
   logic [31:0] w_mag_q;
   logic [31:0] w_mag_r;
   logic [31:0] w_quo_s;
   logic [31:0] w_rem_s;
   logic [31:0] w_quo_u;
   logic [31:0] w_rem_u;

   assign w_b_zero = (b == 32'd0);
   assign w_b_safe = w_b_zero ? 32'd1 : b;
   assign w_abs_a  = a[31] ? (32'd0 - a) : a;
   assign w_abs_b  = w_b_safe[31] ? (32'd0 - w_b_safe) : w_b_safe;
   assign w_mag_q  = w_abs_a / w_abs_b;
   assign w_mag_r  = w_abs_a % w_abs_b;
   assign w_quo_s  = (a[31] ^ b[31]) ? (32'd0 - w_mag_q) : w_mag_q;
   assign w_rem_s  = a[31] ? (32'd0 - w_mag_r) : w_mag_r;   // sign of dividend
   assign w_quo_u  = a / w_b_safe;
   assign w_rem_u  = a % w_b_safe;

   // ---------------- control ----------------
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_busy    <= 1'b0;
         r_hi      <= '0;
         r_lo      <= '0;
         r_pend_hi <= '0;
         r_pend_lo <= '0;
         r_commit  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start) begin
                  case (op)
                     3'd1, 3'd2: begin
                        {r_pend_hi, r_pend_lo} <= (op == 3'd1) ? w_prod_s : w_prod_u;
                        r_commit <= 1'b1;
                        r_cnt    <= CW'(MULT_CYCLES);
                        r_busy   <= 1'b1;
                        r_state  <= RUN;
                     end
                     3'd3, 3'd4: begin
                        r_pend_hi <= (op == 3'd3) ? w_rem_s : w_rem_u;
                        r_pend_lo <= (op == 3'd3) ? w_quo_s : w_quo_u;
                        r_commit  <= ~w_b_zero;
                        r_cnt     <= CW'(DIV_CYCLES);
                        r_busy    <= 1'b1;
                        r_state   <= RUN;
                     end
                     3'd5:    r_hi <= a;
                     3'd6:    r_lo <= a;
                     default: ;
                  endcase
               end
            end
            RUN: begin
               // start is deliberately ignored here: the stall logic never
               // lets a second MDU op reach E while busy.
               if (r_cnt == CW'(1)) begin
                  if (r_commit) begin
                     r_hi <= r_pend_hi;
                     r_lo <= r_pend_lo;
                  end
                  r_cnt   <= '0;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end else begin
                  r_cnt <= r_cnt - CW'(1);
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign busy = r_busy;
   assign hi   = r_hi;
   assign lo   = r_lo;

endmodule

// File: tb/tb_mdu.sv
// ---------------------------------------------------------------------------
// tb_mdu -- self-checking bench for mdu (MULT_CYCLES=5, DIV_CYCLES=10).
// A table of {op, a, b, expected hi/lo, expected busy length} records is
// issued one at a time; each issue pushes its expectation onto a scoreboard
// queue, which is popped when busy drops and compared against HI/LO.
// Hand-written sequences cover reset during a divide and start-while-busy.
// ---------------------------------------------------------------------------
module tb_mdu;

   logic        clk = 1'b0;
   logic        rst;
   logic        start;
   logic [2:0]  op;
   logic [31:0] a;
   logic [31:0] b;
   logic        busy;
   logic [31:0] hi;
   logic [31:0] lo;

   always #5 clk = ~clk;

   mdu #(
      .MULT_CYCLES(5),
      .DIV_CYCLES (10)
   ) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .op   (op),
      .a    (a),
      .b    (b),
      .busy (busy),
      .hi   (hi),
      .lo   (lo)
   );

   typedef struct {
      logic [2:0]  op;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] e_hi;
      logic [31:0] e_lo;
      int          e_cyc;
   } vec_t;

   vec_t        vecs[16];
   vec_t        sb_q[$];
   int          n_pass = 0;
   int          n_total = 0;
   logic        ill_chk_en = 1'b1;
   logic [31:0] cur_hi = 32'd0;
   logic [31:0] cur_lo = 32'd0;

   // A start pulse while busy is illegal in the pipeline; flag it unless a
   // test deliberately provokes it.
   always @(posedge clk) begin
      if (ill_chk_en && !rst && start && busy)
         $error("FAIL illegal_start: start=1 busy=1 required busy=0");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got 0x%08h required 0x%08h", name, act, exp);
   endtask

   task automatic issue(input logic [2:0] i_op, input logic [31:0] i_a, input logic [31:0] i_b,
                        input logic [31:0] e_hi, input logic [31:0] e_lo, input int e_cyc);
      vec_t v;
      v.op = i_op; v.a = i_a; v.b = i_b; v.e_hi = e_hi; v.e_lo = e_lo; v.e_cyc = e_cyc;
      @(negedge clk);
      start = 1'b1; op = i_op; a = i_a; b = i_b;
      sb_q.push_back(v);
      @(posedge clk);
      #1;
      start = 1'b0; op = 3'd0;
   endtask

   // Count busy cycles (bounded), check HI/LO hold while busy, then pop the
   // scoreboard and compare the committed result.
   task automatic drain(input string tag);
      vec_t e;
      int   cnt;
      e   = sb_q.pop_front();
      cnt = 0;
      @(negedge clk);
      while (busy === 1'b1 && cnt < 50) begin
         if (cnt == 0) begin
            check({tag, "_hold_hi"}, hi, cur_hi);
            check({tag, "_hold_lo"}, lo, cur_lo);
         end
         cnt++;
         @(negedge clk);
      end
      check({tag, "_busy_cycles"}, 32'(cnt), 32'(e.e_cyc));
      check({tag, "_hi"}, hi, e.e_hi);
      check({tag, "_lo"}, lo, e.e_lo);
      $display("%s op=%0d a=%08h b=%08h busy=%0d hi=%08h lo=%08h", tag, e.op, e.a, e.b, cnt, hi, lo);
      cur_hi = e.e_hi;
      cur_lo = e.e_lo;
   endtask

   initial begin
      vec_t e;
      int   cnt;

      vecs[0]  = '{3'd5, 32'h0000_1234, 32'h0,          32'h0000_1234, 32'h0000_0000, 0};
      vecs[1]  = '{3'd6, 32'h0000_5678, 32'h0,          32'h0000_1234, 32'h0000_5678, 0};
      vecs[2]  = '{3'd1, 32'hFFFF_FFFE, 32'h3,          32'hFFFF_FFFF, 32'hFFFF_FFFA, 5};
      vecs[3]  = '{3'd2, 32'hFFFF_FFFE, 32'h3,          32'h0000_0002, 32'hFFFF_FFFA, 5};
      vecs[4]  = '{3'd3, 32'hFFFF_FFF9, 32'h2,          32'hFFFF_FFFF, 32'hFFFF_FFFD, 10};
      vecs[5]  = '{3'd4, 32'h0000_0007, 32'h2,          32'h0000_0001, 32'h0000_0003, 10};
      vecs[6]  = '{3'd3, 32'h8000_0000, 32'hFFFF_FFFF,  32'h0000_0000, 32'h8000_0000, 10};
      vecs[7]  = '{3'd5, 32'h0000_00AA, 32'h0,          32'h0000_00AA, 32'h8000_0000, 0};
      vecs[8]  = '{3'd6, 32'h0000_00BB, 32'h0,          32'h0000_00AA, 32'h0000_00BB, 0};
      vecs[9]  = '{3'd3, 32'h0000_0005, 32'h0,          32'h0000_00AA, 32'h0000_00BB, 10};
      vecs[10] = '{3'd4, 32'h0000_0005, 32'h0,          32'h0000_00AA, 32'h0000_00BB, 10};
      vecs[11] = '{3'd0, 32'h1111_1111, 32'h2,          32'h0000_00AA, 32'h0000_00BB, 0};
      vecs[12] = '{3'd7, 32'h2222_2222, 32'h3,          32'h0000_00AA, 32'h0000_00BB, 0};
      vecs[13] = '{3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF,  32'h3FFF_FFFF, 32'h0000_0001, 5};
      vecs[14] = '{3'd3, 32'h0000_0007, 32'hFFFF_FFFE,  32'h0000_0001, 32'hFFFF_FFFD, 10};
      vecs[15] = '{3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001, 5};

      rst = 1'b1; start = 1'b0; op = 3'd0; a = 32'd0; b = 32'd0;
      repeat (3) @(negedge clk);
      check("reset_busy", 32'(busy), 32'd0);
      check("reset_hi", hi, 32'd0);
      check("reset_lo", lo, 32'd0);
      rst = 1'b0;

      for (int i = 0; i < 16; i++) begin
         issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e_hi, vecs[i].e_lo, vecs[i].e_cyc);
         drain($sformatf("vec%0d", i));
      end

      // Reset in the middle of a divide: nothing committed, no late commit.
      issue(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 10);
      void'(sb_q.pop_front());
      cnt = 0;
      @(negedge clk);
      while (busy === 1'b1 && cnt < 4) begin
         cnt++;
         if (cnt < 4) @(negedge clk);
      end
      check("rst_mid_busy_seen", 32'(cnt), 32'd4);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_mid_busy", 32'(busy), 32'd0);
      check("rst_mid_hi", hi, 32'd0);
      check("rst_mid_lo", lo, 32'd0);
      repeat (12) @(negedge clk);
      check("rst_mid_late_hi", hi, 32'd0);
      check("rst_mid_late_lo", lo, 32'd0);
      $display("rst_mid_div busy=%0d hi=%08h lo=%08h", busy, hi, lo);
      cur_hi = 32'd0;
      cur_lo = 32'd0;

      issue(3'd1, 32'd6, 32'd7, 32'd0, 32'd42, 5);
      drain("mult_after_rst");

      // Start pulses while busy must not disturb the in-flight divide.
      ill_chk_en = 1'b0;
      issue(3'd3, 32'd100, 32'd7, 32'd2, 32'd14, 10);
      e   = sb_q.pop_front();
      cnt = 0;
      @(negedge clk);
      while (busy === 1'b1 && cnt < 50) begin
         cnt++;
         if (cnt == 2) begin
            start = 1'b1; op = 3'd5; a = 32'hDEAD_BEEF; b = 32'd0;
         end else if (cnt == 5) begin
            start = 1'b1; op = 3'd1; a = 32'd3; b = 32'd3;
         end else begin
            start = 1'b0; op = 3'd0;
         end
         @(negedge clk);
      end
      start = 1'b0; op = 3'd0;
      check("ill_busy_cycles", 32'(cnt), 32'(e.e_cyc));
      check("ill_hi", hi, e.e_hi);
      check("ill_lo", lo, e.e_lo);
      @(negedge clk);
      check("ill_no_restart", 32'(busy), 32'd0);
      $display("start_while_busy busy=%0d hi=%08h lo=%08h", cnt, hi, lo);
      ill_chk_en = 1'b1;

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
